// File: rtl/orb_pkg.sv
// rtl/orb_pkg.sv - shared orbital-word constants and serializer FSM states
package orb_pkg;

  localparam int ORB_WORD_W = 12;
  localparam int ORB_ADDR_W = 11;
  localparam int ORB_DEPTH  = 2048;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAITD,
    SHIFT
  } orb_state_e;

endpackage

// File: rtl/orb_sync_edge.sv
// rtl/orb_sync_edge.sv - 2-flop synchronizer with change detect on the synchronized level
module orb_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_change
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_change = r_sync ^ r_prev;

endmodule

// File: rtl/orb_word_serializer.sv
// rtl/orb_word_serializer.sv - fetches orbital words from RAM and shifts them out MSB-first
module orb_word_serializer
  import orb_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = ORB_WORD_W,
  parameter int ADDR_W  = ORB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              SW,
  input  logic [WORD_W-1:0] rdData,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              RE,
  output logic              sOut,
  output logic              busy,
  output logic              frameStart,
  output logic              errOvr
);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(WORD_W - 1);

  orb_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_shift;
  logic [DIV_W-1:0]  r_div;
  logic [3:0]        r_bit;
  logic              r_re;
  logic              r_busy;
  logic              r_frame;
  logic              r_err;
  logic              r_restart;
  logic              w_sw_change;

  orb_sync_edge u_sw_sync (
    .clk      (clk),
    .rst_n    (rst),
    .i_async  (SW),
    .o_change (w_sw_change)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_shift   <= '0;
      r_div     <= '0;
      r_bit     <= '0;
      r_re      <= 1'b0;
      r_busy    <= 1'b0;
      r_frame   <= 1'b0;
      r_err     <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_re    <= 1'b0;
      r_frame <= 1'b0;
      r_err   <= req && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (r_restart) begin
            r_restart <= 1'b0;
            r_addr    <= '0;
          end
          if (req) begin
            r_state <= READ;
            r_re    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        READ: r_state <= WAITD;
        WAITD: begin
          r_shift <= rdData;
          r_div   <= '0;
          r_bit   <= '0;
          r_frame <= (r_addr == '0);
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            // Clearing the shift register on the last bit is what returns sOut low.
            if (r_bit == BIT_LAST) begin
              r_shift <= '0;
              r_addr  <= r_addr + 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_shift <= {r_shift[WORD_W-2:0], 1'b0};
              r_bit   <= r_bit + 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A page switch seen mid-word is held until the next IDLE cycle.
      if (w_sw_change) r_restart <= 1'b1;
    end
  end

  assign RdAddr     = r_addr;
  assign RE         = r_re;
  assign sOut       = r_shift[WORD_W-1];
  assign busy       = r_busy;
  assign frameStart = r_frame;
  assign errOvr     = r_err;

endmodule

// File: tb/tb_orb_word_serializer.sv
// tb/tb_orb_word_serializer.sv - directed self-checking bench for orb_word_serializer
module tb_orb_word_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        req2 = 1'b0;
  logic        SW = 1'b0;
  logic [11:0] rd1 = '0;
  logic [11:0] rd2 = '0;
  logic [10:0] addr1, addr2;
  logic        re1, re2, sout1, sout2, busy1, busy2, fs1, fs2, err1, err2;

  int checks = 0;
  int failures = 0;

  logic [11:0] mem [0:2047];

  logic [11:0] rw_word;
  logic [10:0] rw_addr;
  int          rw_re, rw_fs, rw_err, rw_busy_bad, rw_glitch;

  typedef struct {
    logic [11:0] data;
    logic [11:0] exp_word;
    logic [10:0] exp_addr;
    int          exp_fs;
  } vec_t;
  vec_t vt [5];

  orb_word_serializer u_dut (
    .clk(clk), .rst(rst), .req(req), .SW(SW), .rdData(rd1),
    .RdAddr(addr1), .RE(re1), .sOut(sout1), .busy(busy1),
    .frameStart(fs1), .errOvr(err1)
  );

  orb_word_serializer #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .SW(SW), .rdData(rd2),
    .RdAddr(addr2), .RE(re2), .sOut(sout2), .busy(busy2),
    .frameStart(fs2), .errOvr(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (re1) rd1 <= mem[addr1];
    if (re2) rd2 <= mem[addr2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One 51-cycle word on u_dut; optional extra req and SW toggle at given cycles.
  task run_word(input int extra_at, input int sw_at);
    int idx;
    rw_word = '0; rw_addr = '0;
    rw_re = 0; rw_fs = 0; rw_err = 0; rw_busy_bad = 0; rw_glitch = 0;
    req = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      req = (c == extra_at - 1);
      if (c == sw_at) SW = ~SW;
      if (re1) begin rw_re++; rw_addr = addr1; end
      if (fs1) rw_fs = c;
      if (err1) rw_err++;
      if (busy1 !== (c <= 50)) rw_busy_bad++;
      if (c >= 3 && c <= 50) begin
        idx = 11 - (c - 3) / 4;
        if ((c - 3) % 4 == 0) rw_word[idx] = sout1;
        else if (sout1 !== rw_word[idx]) rw_glitch++;
      end else if (sout1 !== 1'b0) rw_glitch++;
    end
  endtask

  task check_word(input string tag, input logic [11:0] w, input logic [10:0] a, input int fs, input int errs);
    check({tag, "_word"}, rw_word, w);
    check({tag, "_re_count"}, rw_re, 1);
    check({tag, "_re_addr"}, rw_addr, a);
    check({tag, "_frame_cycle"}, rw_fs, fs);
    check({tag, "_err_count"}, rw_err, errs);
    check({tag, "_busy_bad"}, rw_busy_bad, 0);
    check({tag, "_sout_glitch"}, rw_glitch, 0);
  endtask

  initial begin
    int wrap_bad, wrap_re, wrap_fs, wrap_err, exp_a;
    for (int i = 0; i < 2048; i++) mem[i] = 12'(i * 3 + 1);
    vt[0] = '{12'h5A8, 12'h5A8, 11'd0, 3};
    vt[1] = '{12'hFFF, 12'hFFF, 11'd1, 0};
    vt[2] = '{12'h001, 12'h001, 11'd2, 0};
    vt[3] = '{12'h800, 12'h800, 11'd3, 0};
    vt[4] = '{12'hA5A, 12'hA5A, 11'd4, 0};

    repeat (3) @(negedge clk);
    check("rst_rdaddr", addr1, 0);
    check("rst_re", re1, 0);
    check("rst_sout", sout1, 0);
    check("rst_busy", busy1, 0);
    check("rst_frame", fs1, 0);
    check("rst_err", err1, 0);
    rst = 1'b1;
    @(negedge clk);

    // Wrap-around walk on the CLK_DIV=2 instance: 27-cycle spacing.
    wrap_bad = 0; wrap_re = 0; wrap_fs = 0; wrap_err = 0;
    for (int n = 0; n < 2050; n++) begin
      req2 = 1'b1;
      exp_a = n % 2048;
      for (int c = 1; c <= 27; c++) begin
        @(negedge clk);
        req2 = 1'b0;
        if (re2) begin
          wrap_re++;
          if (addr2 !== 11'(exp_a)) wrap_bad++;
        end
        if (fs2) wrap_fs++;
        if (err2) wrap_err++;
      end
    end
    check("wrap_addr_order_bad", wrap_bad, 0);
    check("wrap_re_count", wrap_re, 2050);
    check("wrap_frame_count", wrap_fs, 2);
    check("wrap_err_count", wrap_err, 0);

    for (int v = 0; v < 5; v++) begin
      mem[vt[v].exp_addr] = vt[v].data;
      run_word(0, 0);
      check_word($sformatf("vec%0d", v), vt[v].exp_word, vt[v].exp_addr, vt[v].exp_fs, 0);
      check($sformatf("vec%0d_rdaddr_next", v), addr1, 32'(vt[v].exp_addr) + 1);
    end

    mem[5] = 12'h3C6;
    run_word(0, 20);
    check_word("sw_shift", 12'h3C6, 11'd5, 0, 0);
    check("sw_shift_rdaddr_after", addr1, 6);
    mem[0] = 12'h9E1;
    run_word(0, 0);
    check_word("sw_restart", 12'h9E1, 11'd0, 3, 0);

    mem[1] = 12'h111;
    mem[2] = 12'h222;
    run_word(20, 0);
    check_word("ovr", 12'h111, 11'd1, 0, 1);
    run_word(0, 0);
    check_word("ovr_next", 12'h222, 11'd2, 0, 0);

    SW = ~SW;
    repeat (5) @(negedge clk);
    SW = ~SW;
    repeat (5) @(negedge clk);
    run_word(0, 0);
    check_word("sw_idle2", 12'h9E1, 11'd0, 3, 0);

    mem[1] = 12'hFFF;
    req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req = 1'b0;
    end
    check("pre_rst_sout", sout1, 1);
    check("pre_rst_busy", busy1, 1);
    check("pre_rst_rdaddr", addr1, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_sout", sout1, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_rdaddr", addr1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_word(0, 0);
    check_word("post_rst", 12'h9E1, 11'd0, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/orb_word_serializer.md
# orb_word_serializer

Downstream consumer of the orbital-word RAM filled by the two-channel packer. On each word request it reads the next 12-bit orbital word from the RAM's read port, then shifts it out MSB-first on a single serial line at a fixed bit rate. It walks the 2048-word buffer sequentially with wrap-around, restarts at address 0 on a page switch (SW edge), and flags requests it cannot serve.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per serial bit; legal range 2..255.
- WORD_W, 12: orbital word width.
- ADDR_W, 11: RAM address width (2048 words).

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset; asynchronous and active-low.
- req  in  1  word request, one-cycle pulse, synchronous to clk.
- SW  in  1  page-switch level, asynchronous; any edge restarts the buffer walk.
- rdData  in  WORD_W  RAM read data, valid the cycle after RE.
- RdAddr  out  ADDR_W  RAM read address.
- RE  out  1  RAM read enable, one-cycle pulse.
- sOut  out  1  serial data, MSB first; idles low.
- busy  out  1  high while a word is being fetched or shifted.
- frameStart  out  1  one-cycle pulse when shifting of the word from address 0 begins.
- errOvr  out  1  one-cycle pulse when req arrives while busy.

## Operation
- Reset values: RdAddr=0, RE=0, sOut=0, busy=0, frameStart=0, errOvr=0, state=IDLE, shift register=0, bit and divider counters=0, SW sync and edge-detect flops=0.
- SW is passed through a 2-flop synchronizer. Any change of the synchronized value against its previous value sets a sticky restart flag.
- FSM states:
  - IDLE: if the restart flag is set, clear it and set RdAddr=0, in the same cycle as any req. Then, on req, go to READ.
  - READ: RE=1 for exactly one cycle with the current RdAddr. Go to WAITD.
  - WAITD: capture rdData into the shift register, clear the bit and divider counters, and go to SHIFT. If RdAddr==0, pulse frameStart on the first SHIFT cycle.
  - SHIFT: sOut = shift register MSB. Every CLK_DIV cycles, shift left and increment the bit counter. After bit WORD_W-1 has been held for CLK_DIV cycles, RdAddr increments (wrapping 2047→0), sOut returns to 0, and the FSM goes to IDLE.
- A req outside IDLE is dropped and pulses errOvr in the same cycle. The request is not queued.
- A SW edge during READ, WAITD or SHIFT does not abort the current word. The word completes and increments the address, then the restart is applied on the next IDLE cycle, so the next word comes from address 0.
- Multiple SW edges before IDLE collapse into a single restart.
- Counters use full width and compare against constants. The divider counter is sized to hold CLK_DIV-1, and the bit counter is 4 bits wide.
- Reset mid-word forces all state to reset values immediately. sOut goes low asynchronously.

## Timing
- req sampled high at edge k (FSM in IDLE):
  - RE=1 and busy=1 during cycle k+1.
  - rdData is consumed at edge k+2.
  - sOut carries bit 11 from cycle k+3 through k+3+CLK_DIV-1.
  - The last bit ends at cycle k+2+WORD_W·CLK_DIV.
  - busy falls in the cycle after that last bit cycle.
- Minimum req spacing for no errOvr: WORD_W·CLK_DIV+3 cycles (51 at the defaults).
- frameStart is coincident with the first cycle of bit 11 of the address-0 word.
- RdAddr changes only in the cycle after the last bit, or on restart in IDLE. It is stable while RE=1.

## Structure
- Shared package orb_pkg holds:
  - ORB_WORD_W=12, ORB_ADDR_W=11, ORB_DEPTH=2048;
  - the FSM state enum (IDLE, READ, WAITD, SHIFT).
- The packer and this block use the same package.
- One natural sub-module: orb_sync_edge, a 2-flop synchronizer plus change detector, used for SW.
- The rest is a single FSM with datapath.

## Test plan
- Reset then req with rdData=12'h5A8 at address 0:
  - RE at k+1 with RdAddr=0;
  - sOut serial 0101_1010_1000 MSB first, 4 cycles per bit;
  - frameStart at k+3;
  - RdAddr=1 after the word.
- Back-to-back reqs every 51 cycles over 2050 words: addresses 0..2047,0,1 in order; frameStart exactly twice; errOvr never asserted.
- req at 20 cycles after a previous req: errOvr pulses once, the word is not repeated, the next valid req reads the following address.
- SW toggled during SHIFT of the address-5 word: word 5 completes unchanged; the next req reads address 0 with frameStart.
- SW toggled twice while in IDLE before a req: a single restart; the next read is at address 0.
- rst asserted mid-SHIFT: sOut, busy and RdAddr go to 0 immediately; after release, the first req reads address 0.
